alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 16, giving the operand/result width.
REQ-002 The block SHALL have port I_CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port I_RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports I_REQ0_VALID/I_REQ1_VALID, input, 1 each, meaning requester k has a pending operation.
REQ-005 The block SHALL have ports O_REQ0_READY/O_REQ1_READY, output, 1 each, meaning the operation from requester k is accepted this cycle.
REQ-006 The block SHALL have ports I_REQk_OPCODE (5), I_REQk_A (P_WIDTH) and I_REQk_B (P_WIDTH), all inputs, carrying requester k's opcode and operands.
REQ-007 The block SHALL have ports O_RSPk_VALID, output, 1, meaning a result for requester k is held.
REQ-008 The block SHALL have ports I_RSPk_READY, input, 1, meaning requester k consumes the result this cycle.
REQ-009 The block SHALL have ports O_RSPk_C (P_WIDTH) and O_RSPk_STATUS (5), outputs, carrying requester k's result and status flags.
REQ-010 The block SHALL have ports O_ALU_OPCODE (5), O_ALU_A (P_WIDTH) and O_ALU_B (P_WIDTH), outputs, which drive the shared combinational ALU.
REQ-011 The block SHALL have ports I_ALU_C (P_WIDTH) and I_ALU_STATUS (5), inputs, carrying the ALU's result and status.
REQ-012 The block SHALL have port O_BUSY, output, 1, high in any state other than S_IDLE.

Function
REQ-013 The FSM SHALL have states S_IDLE, S_EXEC and S_RESP, plus a 1-bit round-robin pointer PRIO (the requester favoured on a tie).
REQ-014 Grant in S_IDLE SHALL be combinational:
- only one valid: grant that requester;
- both valid: grant requester PRIO;
- no valid: no grant.
REQ-015 O_REQk_READY SHALL be high only in S_IDLE and only for the granted requester; it is low in all other states.
REQ-016 Accept SHALL occur when VALID&&READY. On accept the block SHALL register the opcode, A, B and owner ID, set PRIO to the non-owner, and go to S_EXEC.
REQ-017 In S_EXEC the registered opcode/A/B SHALL drive the O_ALU_* ports. At the end of that cycle I_ALU_C/I_ALU_STATUS SHALL be captured into the result registers, and the FSM SHALL go to S_RESP.
REQ-018 Outside S_EXEC, O_ALU_* SHALL hold the last registered values; the block SHALL not zero them.
REQ-019 In S_RESP, O_RSP<owner>_VALID SHALL be high and the other O_RSP_VALID low. C/STATUS SHALL be stable until I_RSP<owner>_READY is high, after which the FSM returns to S_IDLE on the next edge.
REQ-020 Latency SHALL be: accept at edge N; O_RSP valid from cycle N+2; next accept no earlier than the cycle after the response handshake. Throughput is at most one operation per 3 cycles.
REQ-021 O_RSPk_C/STATUS SHALL be driven from the shared result registers for both k; only VALID distinguishes the owner.
REQ-022 I_RSP_READY of the non-owner SHALL be ignored; requester inputs SHALL be ignored outside S_IDLE.
REQ-023 A requester that drops VALID before accept SHALL never be granted that request. There is no starvation: with both requesters continuously valid, grants SHALL alternate 0,1,0,1.

Reset
REQ-024 When I_RESET is high at a clock edge: state=S_IDLE; PRIO=0; opcode/A/B/result/status/owner registers=0; all READY/VALID outputs and O_BUSY low from the following cycle.
REQ-025 Reset SHALL override any in-flight operation; a pending result is discarded without handshake.
REQ-026 Reset SHALL dominate a simultaneous accept or response handshake.

Structure
REQ-027 State encodings (S_IDLE=0, S_EXEC=1, S_RESP=2, 2 bits) and the opcode width constant (5) SHALL live in a shared package used with the ALU.
REQ-028 The grant logic SHALL be one sub-module, rr_arbiter_2 (inputs: valids, PRIO; output: one-hot grant). The ALU itself stays outside this block.

Verification
REQ-029 Single request: REQ0 valid with opcode ADD, A=0x0003, B=0x0004; ALU model returns 0x0007 -> READY0 at cycle N, RSP0_VALID from N+2 with C=0x0007, and READY1/RSP1_VALID low throughout.
REQ-030 Contention: both requesters valid continuously with RSP_READY tied high, after reset -> grant order 0,1,0,1; each response matches its owner's operands.
REQ-031 Back-pressure: hold I_RSP0_READY low for 5 cycles -> RSP0_VALID and C stay stable, no new READY, O_BUSY high; release -> S_IDLE on the next edge.
REQ-032 Wrap: A=0xFFFF, B=0x0001, ADD -> C=0x0000 and STATUS equal to I_ALU_STATUS captured in S_EXEC (carry flag set).
REQ-033 Reset mid-operation: assert I_RESET while in S_EXEC and again while in S_RESP -> next cycle all VALID/READY low, PRIO=0, and the next grant goes to REQ0 when both are valid.
REQ-034 Non-owner ready: in S_RESP owned by 0, pulse I_RSP1_READY -> no state change; the result is still held for requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and the ALU it fronts:
// FSM encoding, opcode/status widths and opcode values.
package alu_arbiter_pkg;

   localparam int OPCODE_W = 5;
   localparam int STATUS_W = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_ADD = 5'd0;
   localparam logic [OPCODE_W-1:0] OP_SUB = 5'd1;
   localparam logic [OPCODE_W-1:0] OP_AND = 5'd2;
   localparam logic [OPCODE_W-1:0] OP_OR  = 5'd3;
   localparam logic [OPCODE_W-1:0] OP_XOR = 5'd4;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response/ALU signal bundle of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requester-and-ALU environment.
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int P_WIDTH = 16
);

   logic                I_REQ0_VALID;
   logic                I_REQ1_VALID;
   logic                O_REQ0_READY;
   logic                O_REQ1_READY;
   logic [OPCODE_W-1:0] I_REQ0_OPCODE;
   logic [OPCODE_W-1:0] I_REQ1_OPCODE;
   logic [P_WIDTH-1:0]  I_REQ0_A;
   logic [P_WIDTH-1:0]  I_REQ1_A;
   logic [P_WIDTH-1:0]  I_REQ0_B;
   logic [P_WIDTH-1:0]  I_REQ1_B;

   logic                O_RSP0_VALID;
   logic                O_RSP1_VALID;
   logic                I_RSP0_READY;
   logic                I_RSP1_READY;
   logic [P_WIDTH-1:0]  O_RSP0_C;
   logic [P_WIDTH-1:0]  O_RSP1_C;
   logic [STATUS_W-1:0] O_RSP0_STATUS;
   logic [STATUS_W-1:0] O_RSP1_STATUS;

   logic [OPCODE_W-1:0] O_ALU_OPCODE;
   logic [P_WIDTH-1:0]  O_ALU_A;
   logic [P_WIDTH-1:0]  O_ALU_B;
   logic [P_WIDTH-1:0]  I_ALU_C;
   logic [STATUS_W-1:0] I_ALU_STATUS;

   logic                O_BUSY;

   modport slave (
      input  I_REQ0_VALID, I_REQ1_VALID,
      input  I_REQ0_OPCODE, I_REQ1_OPCODE, I_REQ0_A, I_REQ1_A, I_REQ0_B, I_REQ1_B,
      output O_REQ0_READY, O_REQ1_READY,
      output O_RSP0_VALID, O_RSP1_VALID,
      input  I_RSP0_READY, I_RSP1_READY,
      output O_RSP0_C, O_RSP1_C, O_RSP0_STATUS, O_RSP1_STATUS,
      output O_ALU_OPCODE, O_ALU_A, O_ALU_B,
      input  I_ALU_C, I_ALU_STATUS,
      output O_BUSY
   );

   modport master (
      output I_REQ0_VALID, I_REQ1_VALID,
      output I_REQ0_OPCODE, I_REQ1_OPCODE, I_REQ0_A, I_REQ1_A, I_REQ0_B, I_REQ1_B,
      input  O_REQ0_READY, O_REQ1_READY,
      input  O_RSP0_VALID, O_RSP1_VALID,
      output I_RSP0_READY, I_RSP1_READY,
      input  O_RSP0_C, O_RSP1_C, O_RSP0_STATUS, O_RSP1_STATUS,
      input  O_ALU_OPCODE, O_ALU_A, O_ALU_B,
      output I_ALU_C, I_ALU_STATUS,
      input  O_BUSY
   );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the requester selected by prio_i. Grant is one-hot or zero.
module rr_arbiter_2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = prio_i ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept in S_IDLE,
// drive the ALU for one cycle in S_EXEC, hold the result in S_RESP.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int P_WIDTH = 16
) (
   input  logic         I_CLK,
   input  logic         I_RESET,
   alu_arbiter_if.slave bus
);

   state_t              state_q,  state_d;
   logic                prio_q,   prio_d;
   logic                owner_q,  owner_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [P_WIDTH-1:0]  a_q,      a_d;
   logic [P_WIDTH-1:0]  b_q,      b_d;
   logic [P_WIDTH-1:0]  c_q,      c_d;
   logic [STATUS_W-1:0] status_q, status_d;

   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] rsp_ready;
   logic [1:0] rsp_valid;
   logic [1:0] grant;

   assign req_valid = {bus.I_REQ1_VALID, bus.I_REQ0_VALID};
   assign rsp_ready = {bus.I_RSP1_READY, bus.I_RSP0_READY};

   rr_arbiter_2 u_rr_arbiter_2 (
      .valid_i (req_valid),
      .prio_i  (prio_q),
      .grant_o (grant)
   );

   // Grant is a subset of valid, so any grant bit in S_IDLE is an accept.
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      opcode_d  = opcode_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      status_d  = status_q;
      req_ready = 2'b00;
      rsp_valid = 2'b00;

      unique case (state_q)
         S_IDLE: begin
            req_ready = grant;
            if (grant != 2'b00) begin
               owner_d  = grant[1];
               prio_d   = ~grant[1];
               opcode_d = grant[1] ? bus.I_REQ1_OPCODE : bus.I_REQ0_OPCODE;
               a_d      = grant[1] ? bus.I_REQ1_A      : bus.I_REQ0_A;
               b_d      = grant[1] ? bus.I_REQ1_B      : bus.I_REQ0_B;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            c_d      = bus.I_ALU_C;
            status_d = bus.I_ALU_STATUS;
            state_d  = S_RESP;
         end
         S_RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q  <= S_IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         opcode_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         status_q <= status_d;
      end
   end

   // The ALU sees the last accepted operands at all times, not only in S_EXEC.
   assign bus.O_ALU_OPCODE  = opcode_q;
   assign bus.O_ALU_A       = a_q;
   assign bus.O_ALU_B       = b_q;

   assign bus.O_REQ0_READY  = req_ready[0];
   assign bus.O_REQ1_READY  = req_ready[1];
   assign bus.O_RSP0_VALID  = rsp_valid[0];
   assign bus.O_RSP1_VALID  = rsp_valid[1];
   assign bus.O_RSP0_C      = c_q;
   assign bus.O_RSP1_C      = c_q;
   assign bus.O_RSP0_STATUS = status_q;
   assign bus.O_RSP1_STATUS = status_q;
   assign bus.O_BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model: each accepted request yields its ALU result two edges later.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_arbiter_if #(.P_WIDTH(W)) bus ();

   alu_arbiter #(.P_WIDTH(W)) dut (
      .I_CLK   (clk),
      .I_RESET (rst),
      .bus     (bus)
   );

   // Environment ALU: carry/borrow in bit 0, zero in bit 1, negative in bit 2.
   function automatic logic [STATUS_W+W-1:0] alu_ref(input logic [OPCODE_W-1:0] op,
                                                     input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
      logic [W:0]   wide;
      logic [W-1:0] c;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_XOR:  wide = {1'b0, a ^ b};
         default: wide = {1'b0, a};
      endcase
      c = wide[W-1:0];
      return {2'b00, c[W-1], (c == '0), wide[W], c};
   endfunction

   assign {bus.I_ALU_STATUS, bus.I_ALU_C} = alu_ref(bus.O_ALU_OPCODE, bus.O_ALU_A, bus.O_ALU_B);

   int checks = 0;
   int errors = 0;

   logic [OPCODE_W-1:0] op0, op1;
   logic [W-1:0]        a0, b0, a1, b1;

   // Model: stage 0 idle, 1 accepted and computing, 2 holding the result.
   int                  m_stage;
   bit                  m_prio;
   bit                  m_owner;
   logic [OPCODE_W-1:0] m_op;
   logic [W-1:0]        m_a, m_b, m_c;
   logic [STATUS_W-1:0] m_st;
   int                  dut_grants[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit v0, input bit v1, input bit rr0, input bit rr1);
      int g;
      @(negedge clk);
      rst               = r;
      bus.I_REQ0_VALID  = v0;
      bus.I_REQ1_VALID  = v1;
      bus.I_REQ0_OPCODE = op0;
      bus.I_REQ0_A      = a0;
      bus.I_REQ0_B      = b0;
      bus.I_REQ1_OPCODE = op1;
      bus.I_REQ1_A      = a1;
      bus.I_REQ1_B      = b1;
      bus.I_RSP0_READY  = rr0;
      bus.I_RSP1_READY  = rr1;
      #1;
      g = -1;
      if (m_stage == 0) begin
         if (v0 && v1) g = m_prio ? 1 : 0;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      if (bus.O_REQ0_READY === 1'b1) dut_grants.push_back(0);
      if (bus.O_REQ1_READY === 1'b1) dut_grants.push_back(1);
      checkOutput("req0_ready", bus.O_REQ0_READY, g == 0);
      checkOutput("req1_ready", bus.O_REQ1_READY, g == 1);
      checkOutput("rsp0_valid", bus.O_RSP0_VALID, m_stage == 2 && !m_owner);
      checkOutput("rsp1_valid", bus.O_RSP1_VALID, m_stage == 2 && m_owner);
      checkOutput("busy", bus.O_BUSY, m_stage != 0);
      checkOutput("alu_opcode", bus.O_ALU_OPCODE, m_op);
      checkOutput("alu_a", bus.O_ALU_A, m_a);
      checkOutput("alu_b", bus.O_ALU_B, m_b);
      if (m_stage == 2) begin
         checkOutput("rsp0_c", bus.O_RSP0_C, m_c);
         checkOutput("rsp1_c", bus.O_RSP1_C, m_c);
         checkOutput("rsp0_status", bus.O_RSP0_STATUS, m_st);
         checkOutput("rsp1_status", bus.O_RSP1_STATUS, m_st);
      end
      @(posedge clk);
      if (r) begin
         m_stage = 0;
         m_prio  = 1'b0;
         m_op    = '0;
         m_a     = '0;
         m_b     = '0;
      end else if (m_stage == 0) begin
         if (g >= 0) begin
            m_owner       = (g == 1);
            m_op          = (g == 1) ? op1 : op0;
            m_a           = (g == 1) ? a1  : a0;
            m_b           = (g == 1) ? b1  : b0;
            {m_st, m_c}   = alu_ref(m_op, m_a, m_b);
            m_prio        = (g == 0);
            m_stage       = 1;
         end
      end else if (m_stage == 1) begin
         m_stage = 2;
      end else if ((!m_owner && rr0) || (m_owner && rr1)) begin
         m_stage = 0;
      end
   endtask

   initial begin
      rst = 1'b1;
      {bus.I_REQ0_VALID, bus.I_REQ1_VALID, bus.I_RSP0_READY, bus.I_RSP1_READY} = 4'b0000;
      op0 = OP_ADD; op1 = OP_ADD;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      bus.I_REQ0_OPCODE = op0; bus.I_REQ1_OPCODE = op1;
      bus.I_REQ0_A = a0; bus.I_REQ0_B = b0; bus.I_REQ1_A = a1; bus.I_REQ1_B = b1;
      m_stage = 0; m_prio = 1'b0; m_owner = 1'b0;
      m_op = '0; m_a = '0; m_b = '0; m_c = '0; m_st = '0;
      repeat (2) @(posedge clk);

      // Single request 3 + 4, then back-pressure with requester 1 knocking.
      op0 = OP_ADD; a0 = 16'h0003; b0 = 16'h0004;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("add_c", bus.O_RSP0_C, 16'h0007);
      checkOutput("add_rsp1_valid", bus.O_RSP1_VALID, 1'b0);
      repeat (5) applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Wrap-around add sets carry and zero.
      a0 = 16'hFFFF; b0 = 16'h0001;
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("wrap_c", bus.O_RSP0_C, 16'h0000);
      checkOutput("wrap_status", bus.O_RSP0_STATUS, 5'h03);

      // Non-owner ready pulse must not release requester 0's result.
      applyStimulus(0, 0, 0, 0, 1);
      #1;
      checkOutput("nonowner_hold", bus.O_RSP0_VALID, 1'b1);
      applyStimulus(0, 0, 0, 1, 0);

      // Reset during S_EXEC, then during S_RESP after a requester-0 win.
      a0 = 16'h0010; b0 = 16'h0020;
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0);
      dut_grants.delete();
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("post_reset_grant", dut_grants.size() > 0 ? dut_grants[0] : -1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 1);

      // Contention from a fresh reset: grants must alternate 0,1,0,1.
      applyStimulus(1, 0, 0, 0, 0);
      dut_grants.delete();
      op0 = OP_SUB; a0 = 16'h0100; b0 = 16'h0001;
      op1 = OP_XOR; a1 = 16'h00F0; b1 = 16'h0F0F;
      repeat (24) applyStimulus(0, 1, 1, 1, 1);
      checkOutput("contention_count", dut_grants.size(), 8);
      for (int i = 0; i < dut_grants.size(); i++) begin
         checkOutput($sformatf("contention_grant%0d", i), dut_grants[i], i % 2);
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         op0 = 5'($urandom_range(0, 6)); a0 = 16'($urandom); b0 = 16'($urandom);
         op1 = 5'($urandom_range(0, 6)); a1 = 16'($urandom); b1 = 16'($urandom);
         applyStimulus($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
